usb_receiver: RTL and testbench
===============================

USB_RECEIVER -- requirements
Module: usb_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit time; the only legal value is 8.
REQ-002 SHALL have port clk  in  1  system clock, 8x the USB bit rate.
REQ-003 SHALL have port n_rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port d_plus  in  1  raw USB D+ line, asynchronous to clk.
REQ-005 SHALL have port d_minus  in  1  raw USB D- line, asynchronous to clk.
REQ-006 SHALL have port r_full  in  1  downstream byte sink cannot accept a byte.
REQ-007 SHALL have port r_data  out  8  last received byte.
REQ-008 SHALL have port r_write  out  1  1-cycle strobe, r_data valid.
REQ-009 SHALL have port rx_pid  out  4  PID of the current/last packet.
REQ-010 SHALL have port rcving  out  1  packet in progress.
REQ-011 SHALL have port rx_done  out  1  1-cycle end-of-packet strobe.
REQ-012 SHALL have port rx_error  out  1  1-cycle strobe coincident with rx_done when the packet was bad.

Function
REQ-013 SHALL pass d_plus and d_minus through 2-FF synchronizers; all logic uses the synced values. Idle J = (1,0), K = (0,1), SE0 = (0,0).
REQ-014 SHALL run a bit timer 0..7; any synced d_plus edge reloads it to 0; the sample point is count==3; with no edge the timer wraps 7->0.
REQ-015 SHALL NRZI-decode at each sample point: bit = 1 if synced d_plus equals the previous sample, else 0; the previous sample resets to 1.
REQ-016 SHALL count consecutive decoded 1s; after six 1s the next bit is discarded if 0 and resets the count; a 1 there is a stuff error.
REQ-017 SHALL shift unstuffed bits LSB-first into an 8-bit register with a 3-bit bit counter.
REQ-018 SHALL implement the FSM IDLE -> SYNC -> PID -> DATA -> EOP -> IDLE, plus an ERR state.
REQ-019 IDLE: leave to SYNC on the first K after J; rcving=1 from that cycle.
REQ-020 SYNC: after 8 bits the byte SHALL equal 8'h80, otherwise go to ERR.
REQ-021 PID: after 8 bits, rx_pid <= byte[3:0]; byte[7:4] SHALL equal ~byte[3:0], otherwise go to ERR; on success go to DATA.
REQ-022 DATA: each completed byte SHALL drive r_data and pulse r_write on the cycle after the sample point of its 8th bit; CRC bytes are also delivered.
REQ-023 DATA: when r_full=1 at the would-be r_write, the byte SHALL be dropped, r_write stays 0, and the packet is flagged bad.
REQ-024 CRC16 SHALL cover all post-PID bits:
  - init 16'hFFFF;
  - fb = bit ^ crc[15];
  - crc <= {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
  For PID 4'h3 or 4'hB, crc at EOP SHALL equal 16'h800D, otherwise the packet is bad. Other PIDs skip the CRC check.
REQ-025 SE0 at a sample point in DATA SHALL go to EOP; a nonzero bit counter at that point is bad (misaligned).
REQ-026 SE0 at a sample point in SYNC or PID SHALL go to ERR.
REQ-027 EOP: on the first J sample, pulse rx_done for 1 cycle, with rx_error = bad flag; rcving=0 on the same cycle; go to IDLE.
REQ-028 Stuff error, SYNC/PID failure, and K at a sample point in EOP SHALL all go to ERR.
REQ-029 ERR: no r_write; wait for SE0 then J, then pulse rx_done and rx_error together and go to IDLE.
REQ-030 The bad flag, CRC, and stuff count SHALL clear on IDLE->SYNC.

Reset
REQ-031 n_rst=0 SHALL immediately force:
  - FSM=IDLE, timer=0, previous sample=1;
  - r_data=8'h00, r_write=0, rx_pid=4'h0, rcving=0, rx_done=0, rx_error=0;
  - CRC=16'hFFFF, synchronizers=J.
REQ-032 Reset asserted mid-packet SHALL abort with no rx_done; after release the block waits in IDLE for the next K.

Verification
REQ-033 ACK (SYNC, PID 8'hD2, EOP) -> rx_pid=4'h2, no r_write, rx_done=1, rx_error=0.
REQ-034 DATA0 zero-length (PID 8'hC3, bytes 8'h00 8'h00) -> two r_write with 8'h00, rx_done=1, rx_error=0; corrupt the 2nd byte to 8'h01 -> rx_error=1.
REQ-035 DATA1 (PID 8'h4B) with payload 8'hFF 8'hFF and correct CRC, stuffed bits inserted -> r_data 8'hFF, 8'hFF then the CRC bytes; no error.
REQ-036 Seven consecutive 1s inside a data byte -> ERR, no r_write for that byte, rx_done and rx_error pulse after EOP+J.
REQ-037 PID 8'hC2 (check fails) -> no r_write; rx_error=1 after EOP.
REQ-038 r_full=1 during the 2nd byte -> that r_write suppressed, rx_error=1 at end; n_rst pulse mid-DATA -> outputs at reset values, no rx_done.

Source files
------------

// File: rtl/usb_receiver.sv
// USB packet receiver: line sync, bit timing, NRZI decode, destuff, SYNC/PID/CRC16 checks, byte delivery.
// Latency: a byte appears on r_data/r_write one cycle after its last bit is sampled; rx_done one cycle after the EOP J sample.
// Backpressure: the line cannot be stalled; a byte completing while r_full is high is dropped and the packet is flagged bad.
module usb_receiver #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       r_full,
    output logic [7:0] r_data,
    output logic       r_write,
    output logic [3:0] rx_pid,
    output logic       rcving,
    output logic       rx_done,
    output logic       rx_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          dp_meta_q, dp_s_q, dm_meta_q, dm_s_q, dp_d1_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          prev_q, prev_d;
    logic [2:0]    ones_q, ones_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [15:0]   crc_q, crc_d;
    logic          bad_q, bad_d;
    logic          se0_seen_q, se0_seen_d;
    logic          j_seen_q, j_seen_d;
    logic [7:0]    r_data_q, r_data_d;
    logic          r_write_q, r_write_d;
    logic [3:0]    rx_pid_q, rx_pid_d;
    logic          rx_done_q, rx_done_d;
    logic          rx_error_q, rx_error_d;

    logic       line_j, line_k, line_se0, sample, nrzi_bit, crc_bad;
    logic [7:0] byte_full;

    assign line_j    = dp_s_q & ~dm_s_q;
    assign line_k    = ~dp_s_q & dm_s_q;
    assign line_se0  = ~dp_s_q & ~dm_s_q;
    assign sample    = (timer_q == T_SAMPLE);
    assign nrzi_bit  = (dp_s_q == prev_q);
    assign byte_full = {nrzi_bit, shift_q[7:1]};
    assign crc_bad   = ((rx_pid_q == 4'h3) || (rx_pid_q == 4'hB)) && (crc_q != 16'h800D);

    // Synchronizers idle at J so a reset never looks like a K edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_s_q    <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_s_q    <= 1'b0;
            dp_d1_q   <= 1'b1;
        end else begin
            dp_meta_q <= d_plus;
            dp_s_q    <= dp_meta_q;
            dm_meta_q <= d_minus;
            dm_s_q    <= dm_meta_q;
            dp_d1_q   <= dp_s_q;
        end
    end

    always_comb begin
        if (dp_s_q != dp_d1_q) begin
            timer_d = '0;
        end else if (timer_q == T_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        crc_d      = crc_q;
        bad_d      = bad_q;
        se0_seen_d = se0_seen_q;
        j_seen_d   = 1'b0;
        r_data_d   = r_data_q;
        r_write_d  = 1'b0;
        rx_pid_d   = rx_pid_q;
        rx_done_d  = 1'b0;
        rx_error_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                j_seen_d = j_seen_q | line_j;
                if (sample) prev_d = dp_s_q;
                if (j_seen_q && line_k) begin
                    state_d    = S_SYNC;
                    prev_d     = 1'b1;
                    ones_d     = '0;
                    shift_d    = '0;
                    bitcnt_d   = '0;
                    crc_d      = 16'hFFFF;
                    bad_d      = 1'b0;
                    se0_seen_d = 1'b0;
                    j_seen_d   = 1'b0;
                end
            end
            S_SYNC, S_PID, S_DATA: begin
                if (sample) begin
                    if (line_se0) begin
                        se0_seen_d = 1'b1;
                        if (state_q == S_DATA) begin
                            state_d = S_EOP;
                            if (bitcnt_q != 3'd0) bad_d = 1'b1;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        prev_d = dp_s_q;
                        // Bit after six 1s must be a stuffed 0, which carries no data.
                        if (ones_q == 3'd6) begin
                            ones_d = '0;
                            if (nrzi_bit) state_d = S_ERR;
                        end else begin
                            ones_d   = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                            shift_d  = byte_full;
                            bitcnt_d = bitcnt_q + 3'd1;
                            if (state_q == S_DATA) begin
                                crc_d = {crc_q[14:0], 1'b0} ^ ((nrzi_bit ^ crc_q[15]) ? 16'h8005 : 16'h0000);
                            end
                            if (bitcnt_q == 3'd7) begin
                                if (state_q == S_SYNC) begin
                                    state_d = (byte_full == 8'h80) ? S_PID : S_ERR;
                                end else if (state_q == S_PID) begin
                                    rx_pid_d = byte_full[3:0];
                                    state_d  = (byte_full[7:4] == ~byte_full[3:0]) ? S_DATA : S_ERR;
                                end else if (r_full) begin
                                    bad_d = 1'b1;
                                end else begin
                                    r_write_d = 1'b1;
                                    r_data_d  = byte_full;
                                end
                            end
                        end
                    end
                end
            end
            S_EOP: begin
                if (sample) begin
                    if (line_j) begin
                        rx_done_d  = 1'b1;
                        rx_error_d = bad_q | crc_bad;
                        state_d    = S_IDLE;
                    end else if (line_k) begin
                        se0_seen_d = 1'b0;
                        state_d    = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (sample) begin
                    if (line_se0) begin
                        se0_seen_d = 1'b1;
                    end else if (line_j && se0_seen_q) begin
                        rx_done_d  = 1'b1;
                        rx_error_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            prev_q     <= 1'b1;
            ones_q     <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            crc_q      <= 16'hFFFF;
            bad_q      <= 1'b0;
            se0_seen_q <= 1'b0;
            j_seen_q   <= 1'b0;
            r_data_q   <= 8'h00;
            r_write_q  <= 1'b0;
            rx_pid_q   <= 4'h0;
            rx_done_q  <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            prev_q     <= prev_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            crc_q      <= crc_d;
            bad_q      <= bad_d;
            se0_seen_q <= se0_seen_d;
            j_seen_q   <= j_seen_d;
            r_data_q   <= r_data_d;
            r_write_q  <= r_write_d;
            rx_pid_q   <= rx_pid_d;
            rx_done_q  <= rx_done_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign r_data   = r_data_q;
    assign r_write  = r_write_q;
    assign rx_pid   = rx_pid_q;
    assign rcving   = (state_q != S_IDLE);
    assign rx_done  = rx_done_q;
    assign rx_error = rx_error_q;
endmodule

// File: tb/tb_usb_receiver.sv
// Bench for usb_receiver: packets are built as byte lists, bit-stuffed and NRZI-encoded onto the line,
// and the received bytes / done / error / PID are compared with a packet-level model.
module tb_usb_receiver;
    logic       clk, n_rst, d_plus, d_minus, r_full;
    logic [7:0] r_data;
    logic       r_write;
    logic [3:0] rx_pid;
    logic       rcving, rx_done, rx_error;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int orphan_cnt = 0;
    int g0, d0, e0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    bit         lbits[$];
    bit         exp_err;
    logic [3:0] exp_pid;

    usb_receiver #(.CLKS_PER_BIT(8)) dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus), .r_full(r_full),
        .r_data(r_data), .r_write(r_write), .rx_pid(rx_pid), .rcving(rcving),
        .rx_done(rx_done), .rx_error(rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_write) got_q.push_back(r_data);
        if (rx_done) begin
            done_cnt++;
            if (rx_error) err_cnt++;
        end else if (rx_error) begin
            orphan_cnt++;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_of(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++) begin
                fb = pkt_q[j][k] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    // USB sends the inverted CRC high bit first.
    task automatic append_crc();
        logic [15:0] c;
        logic [7:0] b0, b1;
        c = ~crc_of(pkt_q.size());
        for (int k = 0; k < 8; k++) begin
            b0[k] = c[15 - k];
            b1[k] = c[7 - k];
        end
        pkt_q.push_back(b0);
        pkt_q.push_back(b1);
    endtask

    function automatic logic [63:0] got_packed(input int start);
        logic [63:0] r;
        r = '0;
        for (int i = start; i < got_q.size(); i++) r = {r[55:0], got_q[i]};
        return r;
    endfunction

    function automatic logic [63:0] exp_packed();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_q.size(); i++) r = {r[55:0], exp_q[i]};
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) lbits.push_back(b[k]);
    endtask

    task automatic build_bits(input logic [7:0] pid);
        lbits.delete();
        push_byte(8'h80);
        push_byte(pid);
        for (int j = 0; j < pkt_q.size(); j++) push_byte(pkt_q[j]);
    endtask

    task automatic model(input logic [7:0] pid, input bit stuff_en, input int full_idx);
        int viol, run;
        bit pid_ok;
        build_bits(pid);
        viol = -1;
        run  = 0;
        if (!stuff_en) begin
            for (int i = 0; i < lbits.size(); i++) begin
                run = lbits[i] ? run + 1 : 0;
                if (run == 7 && viol < 0) viol = i;
            end
        end
        pid_ok  = (pid[7:4] == ~pid[3:0]);
        exp_q.delete();
        exp_pid = pid[3:0];
        exp_err = !pid_ok || (viol >= 0);
        if (pid_ok) begin
            for (int j = 0; j < pkt_q.size(); j++) begin
                if (viol >= 0 && 16 + 8 * j + 7 >= viol) break;
                if (j == full_idx) exp_err = 1'b1;
                else exp_q.push_back(pkt_q[j]);
            end
        end
        if ((pid[3:0] == 4'h3 || pid[3:0] == 4'hB) && crc_of(pkt_q.size()) != 16'h800D) exp_err = 1'b1;
    endtask

    task automatic drive_line(input logic dp, input logic dm, input int n);
        d_plus  = dp;
        d_minus = dm;
        repeat (n) @(negedge clk);
    endtask

    // stop_after >= 0 abandons the packet after that many line bits (no EOP).
    task automatic send_packet(input logic [7:0] pid, input bit stuff_en, input int full_idx, input int stop_after);
        bit tx[$];
        int lg[$];
        int run;
        logic level;
        build_bits(pid);
        run = 0;
        for (int i = 0; i < lbits.size(); i++) begin
            tx.push_back(lbits[i]);
            lg.push_back(i);
            run = lbits[i] ? run + 1 : 0;
            if (stuff_en && run == 6) begin
                tx.push_back(1'b0);
                lg.push_back(-1);
                run = 0;
            end
        end
        level = 1'b1;
        for (int i = 0; i < tx.size(); i++) begin
            if (stop_after >= 0 && i >= stop_after) return;
            if (!tx[i]) level = ~level;
            if (lg[i] >= 16) r_full = ((lg[i] - 16) / 8 == full_idx);
            drive_line(level, ~level, 8);
        end
        r_full = 1'b0;
        drive_line(1'b0, 1'b0, 16);
        drive_line(1'b1, 1'b0, 8);
        repeat (16) @(negedge clk);
    endtask

    task automatic run_pkt(input logic [7:0] pid, input bit stuff_en, input int full_idx);
        g0 = got_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        model(pid, stuff_en, full_idx);
        send_packet(pid, stuff_en, full_idx, -1);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; d_plus = 1'b1; d_minus = 1'b0; r_full = 1'b0;
        #12;
        tests_run++;
        if ({r_data, r_write, rx_pid, rcving, rx_done, rx_error} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, expected 0000", {r_data, r_write, rx_pid, rcving, rx_done, rx_error});
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (rcving !== 1'b0 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle: rcving=%b done=%0d, expected 0 and 0", rcving, done_cnt);
        end
    endtask

    task automatic test_ack();
        pkt_q.delete();
        run_pkt(8'hD2, 1'b1, -1);
        tests_run++;
        if (got_q.size() - g0 != 0) begin
            tests_failed++;
            $display("FAIL ack_writes: got %0d, expected 0", got_q.size() - g0);
        end
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            tests_failed++;
            $display("FAIL ack_done: done=%0d err=%0d, expected 1 and 0", done_cnt - d0, err_cnt - e0);
        end
        tests_run++;
        if (rx_pid !== 4'h2) begin
            tests_failed++;
            $display("FAIL ack_pid: got %h, expected 2", rx_pid);
        end
    endtask

    task automatic test_data0();
        for (int corrupt = 0; corrupt < 2; corrupt++) begin
            pkt_q.delete();
            pkt_q.push_back(8'h00);
            pkt_q.push_back(corrupt ? 8'h01 : 8'h00);
            run_pkt(8'hC3, 1'b1, -1);
            tests_run++;
            if (got_q.size() - g0 != exp_q.size() || got_packed(g0) !== exp_packed()) begin
                tests_failed++;
                $display("FAIL data0_writes[%0d]: got %h, expected %h", corrupt, got_packed(g0), exp_packed());
            end
            tests_run++;
            if (done_cnt - d0 != 1 || err_cnt - e0 != int'(exp_err) || err_cnt - e0 != corrupt) begin
                tests_failed++;
                $display("FAIL data0_done[%0d]: done=%0d err=%0d, expected 1 and %0d", corrupt, done_cnt - d0, err_cnt - e0, corrupt);
            end
        end
    endtask

    task automatic test_data1_stuffed();
        pkt_q.delete();
        pkt_q.push_back(8'hFF);
        pkt_q.push_back(8'hFF);
        append_crc();
        run_pkt(8'h4B, 1'b1, -1);
        tests_run++;
        if (got_q.size() - g0 != 4 || got_packed(g0) !== exp_packed()) begin
            tests_failed++;
            $display("FAIL data1_writes: got %0d bytes %h, expected 4 bytes %h", got_q.size() - g0, got_packed(g0), exp_packed());
        end
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || rx_pid !== 4'hB) begin
            tests_failed++;
            $display("FAIL data1_done: done=%0d err=%0d pid=%h, expected 1 0 b", done_cnt - d0, err_cnt - e0, rx_pid);
        end
    endtask

    task automatic test_stuff_error();
        pkt_q.delete();
        pkt_q.push_back(8'hFF);
        pkt_q.push_back(8'h00);
        run_pkt(8'hC3, 1'b0, -1);
        tests_run++;
        if (got_q.size() - g0 != exp_q.size()) begin
            tests_failed++;
            $display("FAIL stuff_writes: got %0d, expected %0d", got_q.size() - g0, exp_q.size());
        end
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
            tests_failed++;
            $display("FAIL stuff_done: done=%0d err=%0d, expected 1 and 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_bad_pid();
        pkt_q.delete();
        pkt_q.push_back(8'h12);
        pkt_q.push_back(8'h34);
        run_pkt(8'hC2, 1'b1, -1);
        tests_run++;
        if (got_q.size() - g0 != 0) begin
            tests_failed++;
            $display("FAIL badpid_writes: got %0d, expected 0", got_q.size() - g0);
        end
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
            tests_failed++;
            $display("FAIL badpid_done: done=%0d err=%0d, expected 1 and 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_full();
        pkt_q.delete();
        pkt_q.push_back(8'h11);
        pkt_q.push_back(8'h22);
        pkt_q.push_back(8'h33);
        append_crc();
        run_pkt(8'hC3, 1'b1, 1);
        tests_run++;
        if (got_q.size() - g0 != exp_q.size() || got_packed(g0) !== exp_packed()) begin
            tests_failed++;
            $display("FAIL full_writes: got %h, expected %h", got_packed(g0), exp_packed());
        end
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
            tests_failed++;
            $display("FAIL full_done: done=%0d err=%0d, expected 1 and 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_random();
        logic [3:0] n;
        logic [7:0] pid;
        int len, full;
        for (int r = 0; r < 8; r++) begin
            n = 4'($urandom);
            case ($urandom_range(0, 2))
                0: pid = 8'hC3;
                1: pid = 8'h4B;
                default: pid = {~n, n};
            endcase
            pkt_q.delete();
            len = $urandom_range(0, 3);
            for (int j = 0; j < len; j++) pkt_q.push_back(8'($urandom));
            append_crc();
            if (len > 0 && $urandom_range(0, 3) == 0) pkt_q[0] = pkt_q[0] ^ 8'h10;
            full = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 1) : -1;
            run_pkt(pid, 1'b1, full);
            tests_run++;
            if (got_q.size() - g0 != exp_q.size() || got_packed(g0) !== exp_packed()) begin
                tests_failed++;
                $display("FAIL rand%0d_writes: got %h, expected %h (pid %h)", r, got_packed(g0), exp_packed(), pid);
            end
            tests_run++;
            if (done_cnt - d0 != 1 || err_cnt - e0 != int'(exp_err) || rx_pid !== exp_pid) begin
                tests_failed++;
                $display("FAIL rand%0d_done: done=%0d err=%0d pid=%h, expected 1 %0d %h", r, done_cnt - d0, err_cnt - e0, rx_pid, exp_err, exp_pid);
            end
        end
    endtask

    task automatic test_reset_mid();
        pkt_q.delete();
        pkt_q.push_back(8'hAA);
        pkt_q.push_back(8'h55);
        append_crc();
        d0 = done_cnt;
        send_packet(8'hC3, 1'b1, -1, 30);
        n_rst = 1'b0;
        #1;
        tests_run++;
        if ({r_data, r_write, rx_pid, rcving, rx_done, rx_error} !== 16'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h, expected 0000", {r_data, r_write, rx_pid, rcving, rx_done, rx_error});
        end
        d_plus = 1'b1;
        d_minus = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (60) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 0 || rcving !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_nodone: done=%0d rcving=%b, expected 0 and 0", done_cnt - d0, rcving);
        end
        pkt_q.delete();
        run_pkt(8'hD2, 1'b1, -1);
        tests_run++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || rx_pid !== 4'h2) begin
            tests_failed++;
            $display("FAIL midreset_recover: done=%0d err=%0d pid=%h, expected 1 0 2", done_cnt - d0, err_cnt - e0, rx_pid);
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0();
        test_data1_stuffed();
        test_stuff_error();
        test_bad_pid();
        test_full();
        test_random();
        test_reset_mid();
        tests_run++;
        if (orphan_cnt != 0) begin
            tests_failed++;
            $display("FAIL orphan_error: rx_error without rx_done %0d times, expected 0", orphan_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
